// File: rtl/ysyx_23060184_pkg.sv
// Shared constants and helpers for the ysyx_23060184 register file slice.
// Holds default widths, ecall register indices and the read-source selector.
package ysyx_23060184_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_RD     = 2;

  localparam int RV32E_ECALL_REG = 15;
  localparam int RV32I_ECALL_REG = 17;
  localparam int ZERO_REG        = 0;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYPASS,
    SRC_RF
  } rd_src_e;

  // x0 outranks the bypass so a squashed x0 write can never leak through.
  function automatic rd_src_e read_src(input logic is_zero, input logic hit);
    if (is_zero) return SRC_ZERO;
    if (hit)     return SRC_BYPASS;
    return SRC_RF;
  endfunction

endpackage

// File: rtl/ysyx_23060184_regfile_sb_if.sv
// Read/issue/writeback bundle between ID/WB and the register file.
// Read ports are packed: port i occupies slice [i*WIDTH +: WIDTH].
interface ysyx_23060184_regfile_sb_if
  import ysyx_23060184_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_RD     = DEFAULT_NUM_RD
);

  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;
  logic                         ecall;
  logic                         wvalid;
  logic                         wen;
  logic [ADDR_WIDTH-1:0]        waddr;
  logic [DATA_WIDTH-1:0]        wdata;
  logic                         iss_valid;
  logic [ADDR_WIDTH-1:0]        iss_addr;
  logic                         flush;
  logic                         busy_any;

  modport master (
    output raddr, ecall, wvalid, wen, waddr, wdata, iss_valid, iss_addr, flush,
    input  rdata, rbusy, busy_any
  );

  modport slave (
    input  raddr, ecall, wvalid, wen, waddr, wdata, iss_valid, iss_addr, flush,
    output rdata, rbusy, busy_any
  );

endinterface

// File: rtl/ysyx_23060184_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, wiped by flush.
// Bit 0 is tied low because x0 never has a pending producer.
module ysyx_23060184_scoreboard
  import ysyx_23060184_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int NUM_REGS  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  busy_any
);

  logic [NUM_REGS-1:0] busy_nxt;

  // Later assignments win: the issue set overrides a same-cycle clear,
  // and flush overrides both.
  always_comb begin
    // NOTE: default first so every path assigns busy_nxt and no latch is inferred.
    busy_nxt = busy;
    if (we)        busy_nxt[waddr]    = 1'b0;
    if (iss_valid) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
    if (flush)     busy_nxt = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign busy_any = |busy;

endmodule

// File: rtl/ysyx_23060184_regfile_sb.sv
// Integer register file with write-through bypass and an integrated scoreboard.
// Read ports are combinational; one write port commits at the rising edge.
module ysyx_23060184_regfile_sb
  import ysyx_23060184_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_RD     = DEFAULT_NUM_RD,
  parameter int ECALL_REG  = RV32E_ECALL_REG
) (
  input logic                      clk,
  input logic                      reset,
  ysyx_23060184_regfile_sb_if.slave bus
);

  localparam int                    NUM_REGS  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] ECALL_IDX = ADDR_WIDTH'(ECALL_REG);

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  we;

  assign we = bus.wvalid & bus.wen & (bus.waddr != ZERO_IDX);

  always_ff @(posedge clk) begin
    // NOTE: the storage is reset on purpose; software may read registers
    // before writing them and must see zero.
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else if (we) begin
      rf[bus.waddr] <= bus.wdata;
    end
  end

  ysyx_23060184_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.flush),
    .iss_valid(bus.iss_valid),
    .iss_addr (bus.iss_addr),
    .we       (we),
    .waddr    (bus.waddr),
    .busy     (busy),
    .busy_any (bus.busy_any)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ea;
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;

    // Port 1 is redirected to the syscall-number register during ecall.
    if (i == 1) begin : g_ecall
      assign ea = bus.ecall ? ECALL_IDX : bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin : g_plain
      assign ea = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign hit = we & (bus.waddr == ea);

    always_comb begin
      data = '0;
      case (read_src(ea == ZERO_IDX, hit))
        SRC_BYPASS: data = bus.wdata;
        SRC_RF:     data = rf[ea];
        default:    data = '0;
      endcase
    end

    assign bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = data;
    // A writeback landing this cycle resolves the hazard through the bypass.
    assign bus.rbusy[i] = busy[ea] & ~hit;
  end

endmodule

// File: tb/tb_ysyx_23060184_regfile_sb.sv
// Directed table-driven bench for ysyx_23060184_regfile_sb (RV32I sizes, 2 read ports).
// Inputs change #1 after the rising edge; outputs are compared on the falling edge.
module tb_ysyx_23060184_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ysyx_23060184_regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

  ysyx_23060184_regfile_sb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_RD    (NR),
    .ECALL_REG (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          ecall;
    logic          wvalid;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic          flush;
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
    logic [1:0]    e_rbusy;
    logic          e_any;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.raddr     = {v.ra1, v.ra0};
    bus.ecall     = v.ecall;
    bus.wvalid    = v.wvalid;
    bus.wen       = v.wen;
    bus.waddr     = v.waddr;
    bus.wdata     = v.wdata;
    bus.iss_valid = v.iss_valid;
    bus.iss_addr  = v.iss_addr;
    bus.flush     = v.flush;
  endtask

  task automatic compare(input string tag, input vec_t v);
    check({tag, "_rdata0"}, 64'(bus.rdata[DW-1:0]),  64'(v.e_rd0));
    check({tag, "_rdata1"}, 64'(bus.rdata[2*DW-1:DW]), 64'(v.e_rd1));
    check({tag, "_rbusy"},  64'(bus.rbusy),           64'(v.e_rbusy));
    check({tag, "_busy_any"}, 64'(bus.busy_any),      64'(v.e_any));
  endtask

  // Drive a vector, compare at the falling edge, then step to just past the next rising edge.
  task automatic apply(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    compare(tag, v);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t idle_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                   input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                   input logic [1:0] rb, input logic any);
    vec_t v;
    v = '{a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, d0, d1, rb, any};
    return v;
  endfunction

  initial begin
    vec_t v;

    //            ra0 ra1 ecl wv  wen wa  wdata          iv  ia  fl  rd0            rd1            rb    any
    vecs.push_back('{5,  0, 0,  1,  1,  5, 32'hDEADBEEF, 0,  0, 0, 32'hDEADBEEF, 32'h0,        2'b00, 0}); // 0 write + bypass
    vecs.push_back('{5,  5, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0}); // 1 stored
    vecs.push_back('{0,  0, 0,  1,  1,  0, 32'h1234,     0,  0, 0, 32'h0,        32'h0,        2'b00, 0}); // 2 write x0
    vecs.push_back('{3,  5, 0,  0,  1,  3, 32'h1111,     0,  0, 0, 32'h0,        32'hDEADBEEF, 2'b00, 0}); // 3 wvalid=0
    vecs.push_back('{3,  0, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        2'b00, 0}); // 4 x3 unchanged
    vecs.push_back('{7,  0, 0,  0,  0,  0, 32'h0,        1,  7, 0, 32'h0,        32'h0,        2'b00, 0}); // 5 issue x7
    vecs.push_back('{7,  7, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        2'b11, 1}); // 6 x7 busy
    vecs.push_back('{7,  5, 0,  1,  1,  7, 32'h55,       0,  0, 0, 32'h55,       32'hDEADBEEF, 2'b00, 1}); // 7 wb x7
    vecs.push_back('{7,  0, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h55,       32'h0,        2'b00, 0}); // 8 cleared
    vecs.push_back('{7,  0, 0,  1,  1,  7, 32'h66,       1,  7, 0, 32'h66,       32'h0,        2'b00, 0}); // 9 issue+wb x7
    vecs.push_back('{7,  0, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h66,       32'h0,        2'b01, 1}); // 10 set wins
    vecs.push_back('{7,  3, 1,  1,  1, 15, 32'hA5,       0,  0, 0, 32'h66,       32'hA5,       2'b01, 1}); // 11 ecall bypass
    vecs.push_back('{5,  0, 1,  0,  0,  0, 32'h0,        0,  0, 0, 32'hDEADBEEF, 32'hA5,       2'b00, 1}); // 12 ecall stored
    vecs.push_back('{0, 15, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h0,        32'hA5,       2'b00, 1}); // 13 no ecall
    vecs.push_back('{2,  0, 0,  0,  0,  0, 32'h0,        1,  2, 0, 32'h0,        32'h0,        2'b00, 1}); // 14 issue x2
    vecs.push_back('{2,  9, 0,  0,  0,  0, 32'h0,        1,  9, 0, 32'h0,        32'h0,        2'b01, 1}); // 15 issue x9
    vecs.push_back('{2,  9, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        2'b11, 1}); // 16 both busy
    vecs.push_back('{9,  4, 0,  0,  0,  0, 32'h0,        1,  4, 1, 32'h0,        32'h0,        2'b01, 1}); // 17 flush+issue
    vecs.push_back('{9,  4, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        2'b00, 0}); // 18 all clear
    vecs.push_back('{2,  0, 0,  1,  1,  2, 32'h77,       0,  0, 0, 32'h77,       32'h0,        2'b00, 0}); // 19 wb, not busy
    vecs.push_back('{2,  7, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h77,       32'h66,       2'b00, 0}); // 20 stored
    vecs.push_back('{8,  0, 0,  0,  0,  0, 32'h0,        1,  8, 0, 32'h0,        32'h0,        2'b00, 0}); // 21 issue x8
    vecs.push_back('{8,  0, 0,  1,  1,  8, 32'h88,       0,  0, 1, 32'h88,       32'h0,        2'b00, 1}); // 22 flush+wb
    vecs.push_back('{8,  0, 0,  0,  0,  0, 32'h0,        0,  0, 0, 32'h88,       32'h0,        2'b00, 0}); // 23 committed

    // Reset, then sweep every register on both ports.
    reset = 1'b1;
    drive(idle_rd(0, 0, 0, 0, 2'b00, 0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int r = 0; r < 32; r++) begin
      v = idle_rd(AW'(r), AW'(31 - r), 32'h0, 32'h0, 2'b00, 1'b0);
      apply($sformatf("reset_r%0d", r), v);
    end

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-sequence with a pending busy bit, a concurrent write and an issue.
    drive(idle_rd(0, 0, 0, 0, 2'b00, 0));
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd3;
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.iss_addr  = 5'd6;
    bus.wvalid    = 1'b1;
    bus.wen       = 1'b1;
    bus.waddr     = 5'd5;
    bus.wdata     = 32'hCAFE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply("rst_mid_a", idle_rd(5, 3, 32'h0, 32'h0, 2'b00, 1'b0));
    apply("rst_mid_b", idle_rd(6, 7, 32'h0, 32'h0, 2'b00, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_regfile_sb.md
# ysyx_23060184_regfile_sb

Parametrised integer register file with an integrated scoreboard for the pipelined NPC core. Provides NUM_RD combinational read ports with same-cycle write-through bypass, one gated write port, and a per-register busy bit. Busy bits are set at issue and cleared at writeback so that decode can detect RAW hazards. Sits between ID (read, issue) and WB (write); replaces the single-cycle register file.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; 4 selects RV32E (16 regs).
- DATA_WIDTH, 32, register width.
- NUM_RD, 2, number of read ports (≥2).
- ECALL_REG, 15, register returned on read port 1 while ecall is high (17 for RV32I).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- raddr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rbusy  out  NUM_RD  port i source has a pending write.
- ecall  in  1  redirects read port 1 to ECALL_REG.
- wvalid  in  1  WB stage holds a valid instruction.
- wen  in  1  instruction writes rd.
- waddr  in  ADDR_WIDTH  write index.
- wdata  in  DATA_WIDTH  write data.
- iss_valid  in  1  an instruction with destination is issued this cycle.
- iss_addr  in  ADDR_WIDTH  destination of issued instruction.
- flush  in  1  discard all pending writes (pipeline squash).
- busy_any  out  1  OR of all busy bits.

## Operation
- Write commit: we = wvalid & wen & (waddr != 0). On we, rf[waddr] <= wdata.
- Read port i: effective address ea = (i==1 & ecall) ? ECALL_REG : raddr_i.
  - ea == 0 → rdata_i = 0.
  - else if we & waddr == ea → rdata_i = wdata (bypass).
  - else rdata_i = rf[ea].
- Scoreboard, busy[0] hardwired 0. Per register r ≠ 0, next state:
  - reset or flush → 0.
  - iss_valid & iss_addr == r → 1 (set wins over same-cycle clear: newer producer).
  - we & waddr == r → 0.
  - else hold.
- iss_addr == 0 never sets a bit.
- rbusy_i = busy[ea] & ~(we & waddr == ea). Bypass resolves the hazard in the same cycle. ea == 0 → 0.
- busy_any = |busy. Registered state only, no bypass term.
- Write with busy bit already clear (e.g. after flush): data written, busy unaffected.
- Address bits beyond 2**ADDR_WIDTH-1 do not exist; the ECALL_REG parameter must be < 2**ADDR_WIDTH.

## Timing
- Reads: combinational, zero latency, bypass included.
- Writes: visible in rf from the next cycle; visible on rdata in the same cycle via bypass.
- Busy set: visible on rbusy the cycle after iss_valid.
- Busy clear: rbusy drops in the writeback cycle itself.
- Reset: one cycle; all rf entries ← 0, all busy ← 0. Reset overrides a simultaneous write or issue.
- Reset values: rdata = 0, rbusy = 0, busy_any = 0 from the first cycle after reset, with no write in flight.
- Flush + we same cycle: write commits, all busy cleared.
- Flush + iss_valid same cycle: flush wins, bit stays 0.

## Structure
- Shared package ysyx_23060184_pkg holds:
  - RV32E/RV32I ecall register constants (15/17).
  - ZERO_REG = 0.
  - Default widths.
- One sub-module: ysyx_23060184_scoreboard. It holds the busy vector and its set/clear/flush logic, with outputs busy vector and busy_any.
- Read ports are built in a generate loop over NUM_RD.

## Test plan
- Reset then read all regs on both ports → every rdata = 0, rbusy = 0, busy_any = 0.
- Write x5 = 0xDEADBEEF (wvalid=wen=1), same cycle raddr0 = 5 → rdata0 = 0xDEADBEEF. Next cycle, with wen = 0 → still 0xDEADBEEF.
- Write to x0 = 0x1234 → read x0 = 0.
- wvalid = 0, wen = 1 to x3 → x3 unchanged.
- iss x7 → next cycle rbusy for x7 = 1, busy_any = 1. Write x7 = 0x55 → same-cycle rbusy = 0, rdata = 0x55, next cycle busy clear.
- Same-cycle iss x7 and write x7 → x7 busy next cycle.
- ecall = 1 with x15 = 0xA5, raddr1 = 0 → rdata1 = 0xA5, rdata0 unaffected.
- Issue x2 and x9, then flush → both busy clear.
- Assert reset mid-sequence with pending busy and a concurrent write → all zero next cycle, write lost.
